// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with load-use hazard detection, external stall and EX flush.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_instr_valid,
  input  logic [2:0]            i_result_src,
  input  logic [2:0]            i_alu_op,
  input  logic                  i_mem_we,
  input  logic                  i_reg_we,
  input  logic                  i_alu_src,
  input  logic                  i_branch,
  input  logic                  i_jump,
  input  logic [1:0]            i_forward_src,
  input  logic                  i_load_instr,
  input  logic [2:0]            i_func3,
  input  logic                  i_func7_5,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic [XLEN-1:0]       i_rs1_data,
  input  logic [XLEN-1:0]       i_rs2_data,
  input  logic [XLEN-1:0]       i_imm_ext,
  input  logic [XLEN-1:0]       i_pc,
  input  logic [XLEN-1:0]       i_pc_plus4,
  input  logic                  i_stall_ext,
  input  logic                  i_flush,
  output logic [2:0]            o_result_src,
  output logic [2:0]            o_alu_op,
  output logic                  o_mem_we,
  output logic                  o_reg_we,
  output logic                  o_alu_src,
  output logic                  o_branch,
  output logic                  o_jump,
  output logic [1:0]            o_forward_src,
  output logic                  o_load_instr,
  output logic [2:0]            o_func3,
  output logic                  o_func7_5,
  output logic [REG_ADDR_W-1:0] o_rs1_addr,
  output logic [REG_ADDR_W-1:0] o_rs2_addr,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_rs1_used,
  output logic                  o_rs2_used,
  output logic [XLEN-1:0]       o_rs1_data,
  output logic [XLEN-1:0]       o_rs2_data,
  output logic [XLEN-1:0]       o_imm_ext,
  output logic [XLEN-1:0]       o_pc,
  output logic [XLEN-1:0]       o_pc_plus4,
  output logic                  o_valid,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]           o_bubble_cnt,
  output logic [31:0]           o_stall_cnt,
`endif
  output logic                  o_stall_fd
);

  // Fields cleared when a bubble is injected.
  typedef struct packed {
    logic       valid;
    logic [2:0] result_src;
    logic [2:0] alu_op;
    logic       mem_we;
    logic       reg_we;
    logic       branch;
    logic       jump;
    logic [1:0] forward_src;
    logic       load_instr;
  } ctrl_t;

  // Fields that keep their previous value across a bubble.
  typedef struct packed {
    logic                  alu_src;
    logic [2:0]            func3;
    logic                  func7_5;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm_ext;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
  } data_t;

  ctrl_t ctrl_d, ctrl_q, ctrl_in;
  data_t data_d, data_q, data_in;
  logic  hazard;
  logic  rs1_hit, rs2_hit;

  assign ctrl_in = '{
    valid:       i_instr_valid,
    result_src:  i_result_src,
    alu_op:      i_alu_op,
    mem_we:      i_mem_we,
    reg_we:      i_reg_we,
    branch:      i_branch,
    jump:        i_jump,
    forward_src: i_forward_src,
    load_instr:  i_load_instr
  };

  assign data_in = '{
    alu_src:  i_alu_src,
    func3:    i_func3,
    func7_5:  i_func7_5,
    rs1_addr: i_rs1_addr,
    rs2_addr: i_rs2_addr,
    rd_addr:  i_rd_addr,
    rs1_used: i_rs1_used,
    rs2_used: i_rs2_used,
    rs1_data: i_rs1_data,
    rs2_data: i_rs2_data,
    imm_ext:  i_imm_ext,
    pc:       i_pc,
    pc_plus4: i_pc_plus4
  };

  // Load in EX whose destination is read by the instruction sitting in decode.
  assign rs1_hit = i_rs1_used && (i_rs1_addr == data_q.rd_addr);
  assign rs2_hit = i_rs2_used && (i_rs2_addr == data_q.rd_addr);
  assign hazard  = ctrl_q.valid && ctrl_q.load_instr && (data_q.rd_addr != '0) &&
                   i_instr_valid && (rs1_hit || rs2_hit);

  assign o_stall_fd = i_stall_ext || (hazard && !i_flush);

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (i_stall_ext) begin
      ctrl_d = ctrl_q;
    end else if (i_flush || hazard || !i_instr_valid) begin
      ctrl_d = '0;
    end else begin
      ctrl_d = ctrl_in;
      data_d = data_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign o_valid       = ctrl_q.valid;
  assign o_result_src  = ctrl_q.result_src;
  assign o_alu_op      = ctrl_q.alu_op;
  assign o_mem_we      = ctrl_q.mem_we;
  assign o_reg_we      = ctrl_q.reg_we;
  assign o_branch      = ctrl_q.branch;
  assign o_jump        = ctrl_q.jump;
  assign o_forward_src = ctrl_q.forward_src;
  assign o_load_instr  = ctrl_q.load_instr;
  assign o_alu_src     = data_q.alu_src;
  assign o_func3       = data_q.func3;
  assign o_func7_5     = data_q.func7_5;
  assign o_rs1_addr    = data_q.rs1_addr;
  assign o_rs2_addr    = data_q.rs2_addr;
  assign o_rd_addr     = data_q.rd_addr;
  assign o_rs1_used    = data_q.rs1_used;
  assign o_rs2_used    = data_q.rs2_used;
  assign o_rs1_data    = data_q.rs1_data;
  assign o_rs2_data    = data_q.rs2_data;
  assign o_imm_ext     = data_q.imm_ext;
  assign o_pc          = data_q.pc;
  assign o_pc_plus4    = data_q.pc_plus4;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Only hazard bubbles count; flush bubbles and stalled edges do not.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (i_stall_ext && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!i_stall_ext && !i_flush && hazard && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
  assign o_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: vector table through a scoreboard queue,
// plus hand-written external-stall and asynchronous-reset sequences.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 64;
  localparam int RW   = 5;

  logic            i_clk = 1'b0;
  logic            i_arst;
  logic            i_instr_valid;
  logic [2:0]      i_result_src, i_alu_op, i_func3;
  logic            i_mem_we, i_reg_we, i_alu_src, i_branch, i_jump, i_load_instr, i_func7_5;
  logic [1:0]      i_forward_src;
  logic [RW-1:0]   i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic            i_rs1_used, i_rs2_used;
  logic [XLEN-1:0] i_rs1_data, i_rs2_data, i_imm_ext, i_pc, i_pc_plus4;
  logic            i_stall_ext, i_flush;
  logic [2:0]      o_result_src, o_alu_op, o_func3;
  logic            o_mem_we, o_reg_we, o_alu_src, o_branch, o_jump, o_load_instr, o_func7_5;
  logic [1:0]      o_forward_src;
  logic [RW-1:0]   o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic            o_rs1_used, o_rs2_used;
  logic [XLEN-1:0] o_rs1_data, o_rs2_data, o_imm_ext, o_pc, o_pc_plus4;
  logic            o_valid, o_stall_fd;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     o_bubble_cnt, o_stall_cnt;
`endif

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_instr_valid(i_instr_valid),
    .i_result_src(i_result_src), .i_alu_op(i_alu_op), .i_mem_we(i_mem_we),
    .i_reg_we(i_reg_we), .i_alu_src(i_alu_src), .i_branch(i_branch), .i_jump(i_jump),
    .i_forward_src(i_forward_src), .i_load_instr(i_load_instr), .i_func3(i_func3),
    .i_func7_5(i_func7_5), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rd_addr(i_rd_addr), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm_ext(i_imm_ext),
    .i_pc(i_pc), .i_pc_plus4(i_pc_plus4), .i_stall_ext(i_stall_ext), .i_flush(i_flush),
    .o_result_src(o_result_src), .o_alu_op(o_alu_op), .o_mem_we(o_mem_we),
    .o_reg_we(o_reg_we), .o_alu_src(o_alu_src), .o_branch(o_branch), .o_jump(o_jump),
    .o_forward_src(o_forward_src), .o_load_instr(o_load_instr), .o_func3(o_func3),
    .o_func7_5(o_func7_5), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rd_addr(o_rd_addr), .o_rs1_used(o_rs1_used), .o_rs2_used(o_rs2_used),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm_ext(o_imm_ext),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_valid(o_valid),
`ifdef ID_EX_PERF_CNT_EN
    .o_bubble_cnt(o_bubble_cnt), .o_stall_cnt(o_stall_cnt),
`endif
    .o_stall_fd(o_stall_fd)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] imm_of(input int idx);
    return 64'hA5A5_0000_0000_0000 | 64'(idx);
  endfunction

  typedef struct {
    int valid, load, reg_we, mem_we, alu_op, rs1, rs2, rd, rs1_used, rs2_used, flush;
    int e_stall_fd, e_valid, e_reg_we, e_mem_we, e_load, e_alu_op, e_rd, e_imm_idx;
  } vec_t;

  typedef struct {
    int name_idx;
    logic valid, reg_we, mem_we, load;
    logic [2:0] alu_op, result_src;
    logic [1:0] forward_src;
    logic [RW-1:0] rd;
    logic [XLEN-1:0] imm;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  task automatic drive(input int valid, load, reg_we, mem_we, alu_op, rs1, rs2, rd,
                       rs1_used, rs2_used, flush, idx);
    i_instr_valid = 1'(valid);
    i_load_instr  = 1'(load);
    i_reg_we      = 1'(reg_we);
    i_mem_we      = 1'(mem_we);
    i_alu_op      = 3'(alu_op);
    i_result_src  = load != 0 ? 3'd1 : 3'd0;
    i_forward_src = 2'b01;
    i_rs1_addr    = RW'(rs1);
    i_rs2_addr    = RW'(rs2);
    i_rd_addr     = RW'(rd);
    i_rs1_used    = 1'(rs1_used);
    i_rs2_used    = 1'(rs2_used);
    i_flush       = 1'(flush);
    i_imm_ext     = imm_of(idx);
    i_pc          = 64'h8000_0000 + 64'(4 * idx);
    i_pc_plus4    = i_pc + 64'd4;
    i_rs1_data    = {$urandom, $urandom};
    i_rs2_data    = {$urandom, $urandom};
  endtask

  initial begin
    exp_t e;
    // valid load rw mw alu rs1 rs2 rd u1 u2 fl | sfd v rw mw ld alu rd imm
    vecs[0]  = '{1, 0, 1, 0, 2, 1, 2, 3, 1, 1, 0,  0, 1, 1, 0, 0, 2, 3, 0};
    vecs[1]  = '{1, 1, 1, 0, 0, 1, 0, 5, 1, 0, 0,  0, 1, 1, 0, 1, 0, 5, 1};
    vecs[2]  = '{1, 0, 1, 0, 2, 5, 1, 6, 1, 1, 0,  1, 0, 0, 0, 0, 0, 5, 1};
    vecs[3]  = '{1, 0, 1, 0, 2, 5, 1, 6, 1, 1, 0,  0, 1, 1, 0, 0, 2, 6, 3};
    vecs[4]  = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0,  0, 1, 1, 0, 1, 0, 0, 4};
    vecs[5]  = '{1, 0, 1, 0, 2, 0, 0, 7, 1, 1, 0,  0, 1, 1, 0, 0, 2, 7, 5};
    vecs[6]  = '{1, 1, 1, 0, 0, 1, 0, 5, 1, 0, 0,  0, 1, 1, 0, 1, 0, 5, 6};
    vecs[7]  = '{1, 0, 1, 0, 2, 1, 5, 8, 1, 0, 0,  0, 1, 1, 0, 0, 2, 8, 7};
    vecs[8]  = '{1, 1, 1, 0, 0, 1, 0, 5, 1, 0, 0,  0, 1, 1, 0, 1, 0, 5, 8};
    vecs[9]  = '{1, 1, 1, 0, 0, 5, 0, 5, 1, 0, 0,  1, 0, 0, 0, 0, 0, 5, 8};
    vecs[10] = '{1, 1, 1, 0, 0, 5, 0, 5, 1, 0, 0,  0, 1, 1, 0, 1, 0, 5, 10};
    vecs[11] = '{1, 0, 1, 0, 2, 5, 5, 9, 1, 1, 0,  1, 0, 0, 0, 0, 0, 5, 10};
    vecs[12] = '{1, 0, 1, 0, 2, 5, 5, 9, 1, 1, 0,  0, 1, 1, 0, 0, 2, 9, 12};
    vecs[13] = '{1, 1, 1, 0, 0, 1, 0, 5, 1, 0, 0,  0, 1, 1, 0, 1, 0, 5, 13};
    vecs[14] = '{1, 0, 0, 1, 0, 2, 5, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 5, 13};
    vecs[15] = '{0, 0, 1, 0, 2, 5, 5, 9, 1, 1, 0,  0, 0, 0, 0, 0, 0, 5, 13};

    i_arst = 1'b1; i_stall_ext = 1'b0;
    i_alu_src = 1'b0; i_branch = 1'b0; i_jump = 1'b0; i_func3 = 3'd0; i_func7_5 = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_stall_fd_idle", 64'(o_stall_fd), 64'd0);
    i_stall_ext = 1'b1;
    #1;
    check("rst_stall_fd_ext", 64'(o_stall_fd), 64'd1);
    i_stall_ext = 1'b0;
    @(posedge i_clk); #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_imm", o_imm_ext, 64'd0);
    check("rst_pc_plus4", o_pc_plus4, 64'd0);
`ifdef ID_EX_PERF_CNT_EN
    check("rst_bubble_cnt", 64'(o_bubble_cnt), 64'd0);
`endif
    @(negedge i_clk);
    i_arst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      drive(vecs[i].valid, vecs[i].load, vecs[i].reg_we, vecs[i].mem_we, vecs[i].alu_op,
            vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rs1_used, vecs[i].rs2_used,
            vecs[i].flush, i);
      #1;
      check($sformatf("v%0d_stall_fd", i), 64'(o_stall_fd), 64'(vecs[i].e_stall_fd));
      sb.push_back('{i, 1'(vecs[i].e_valid), 1'(vecs[i].e_reg_we), 1'(vecs[i].e_mem_we),
                     1'(vecs[i].e_load), 3'(vecs[i].e_alu_op),
                     vecs[i].e_load != 0 ? 3'd1 : 3'd0,
                     vecs[i].e_valid != 0 ? 2'b01 : 2'b00,
                     RW'(vecs[i].e_rd), imm_of(vecs[i].e_imm_idx)});
      @(posedge i_clk); #1;
      if (sb.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_valid", e.name_idx), 64'(o_valid), 64'(e.valid));
        check($sformatf("v%0d_reg_we", e.name_idx), 64'(o_reg_we), 64'(e.reg_we));
        check($sformatf("v%0d_mem_we", e.name_idx), 64'(o_mem_we), 64'(e.mem_we));
        check($sformatf("v%0d_load", e.name_idx), 64'(o_load_instr), 64'(e.load));
        check($sformatf("v%0d_alu_op", e.name_idx), 64'(o_alu_op), 64'(e.alu_op));
        check($sformatf("v%0d_result_src", e.name_idx), 64'(o_result_src), 64'(e.result_src));
        check($sformatf("v%0d_fwd_src", e.name_idx), 64'(o_forward_src), 64'(e.forward_src));
        check($sformatf("v%0d_rd", e.name_idx), 64'(o_rd_addr), 64'(e.rd));
        check($sformatf("v%0d_imm", e.name_idx), o_imm_ext, e.imm);
      end
    end

    // Store into EX, then freeze for three edges while decode changes underneath.
    @(negedge i_clk);
    drive(1, 0, 0, 1, 0, 2, 4, 0, 1, 1, 0, 20);
    @(posedge i_clk); #1;
    check("sd_mem_we", 64'(o_mem_we), 64'd1);
    check("sd_pc", o_pc, 64'h8000_0000 + 64'd80);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      drive(1, 1, 1, 0, 0, 1, 0, 10, 1, 0, c == 1 ? 1 : 0, 21 + c);
      i_stall_ext = 1'b1;
      #1;
      check($sformatf("stall%0d_stall_fd", c), 64'(o_stall_fd), 64'd1);
      @(posedge i_clk); #1;
      check($sformatf("stall%0d_mem_we", c), 64'(o_mem_we), 64'd1);
      check($sformatf("stall%0d_valid", c), 64'(o_valid), 64'd1);
      check($sformatf("stall%0d_imm", c), o_imm_ext, imm_of(20));
      check($sformatf("stall%0d_rd", c), 64'(o_rd_addr), 64'd0);
    end
`ifdef ID_EX_PERF_CNT_EN
    check("stall_cnt", 64'(o_stall_cnt), 64'd3);
    check("bubble_cnt", 64'(o_bubble_cnt), 64'd3);
`endif

    // Asynchronous reset between edges while still stalled.
    #2;
    i_arst = 1'b1;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_mem_we", 64'(o_mem_we), 64'd0);
    check("arst_imm", o_imm_ext, 64'd0);
    check("arst_pc", o_pc, 64'd0);
    check("arst_stall_fd", 64'(o_stall_fd), 64'd1);
`ifdef ID_EX_PERF_CNT_EN
    check("arst_stall_cnt", 64'(o_stall_cnt), 64'd0);
`endif
    i_stall_ext = 1'b0;
    #1;
    check("arst_stall_fd_clr", 64'(o_stall_fd), 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
